// File: rtl/eco32f_pkg.sv
// Shared definitions for the eco32f ID stage: opcode values, immediate kinds and
// the decoded control bundle carried in the ID/EX register.
package eco32f_pkg;

    localparam logic [5:0] OP_ADD   = 6'h00, OP_ADDI  = 6'h01, OP_SUB   = 6'h02, OP_SUBI  = 6'h03;
    localparam logic [5:0] OP_MUL   = 6'h04, OP_MULI  = 6'h05, OP_MULU  = 6'h06, OP_MULUI = 6'h07;
    localparam logic [5:0] OP_DIV   = 6'h08, OP_DIVI  = 6'h09, OP_DIVU  = 6'h0A, OP_DIVUI = 6'h0B;
    localparam logic [5:0] OP_REM   = 6'h0C, OP_REMI  = 6'h0D, OP_REMU  = 6'h0E, OP_REMUI = 6'h0F;
    localparam logic [5:0] OP_AND   = 6'h10, OP_ANDI  = 6'h11, OP_OR    = 6'h12, OP_ORI   = 6'h13;
    localparam logic [5:0] OP_XOR   = 6'h14, OP_XORI  = 6'h15, OP_XNOR  = 6'h16, OP_XNORI = 6'h17;
    localparam logic [5:0] OP_SLL   = 6'h18, OP_SLLI  = 6'h19, OP_SLR   = 6'h1A, OP_SLRI  = 6'h1B;
    localparam logic [5:0] OP_SAR   = 6'h1C, OP_SARI  = 6'h1D, OP_LDHI  = 6'h1F;
    localparam logic [5:0] OP_BEQ   = 6'h20, OP_BNE   = 6'h21, OP_BLE   = 6'h22, OP_BLEU  = 6'h23;
    localparam logic [5:0] OP_BLT   = 6'h24, OP_BLTU  = 6'h25, OP_BGE   = 6'h26, OP_BGEU  = 6'h27;
    localparam logic [5:0] OP_BGT   = 6'h28, OP_BGTU  = 6'h29, OP_J     = 6'h2A, OP_JR    = 6'h2B;
    localparam logic [5:0] OP_JAL   = 6'h2C, OP_JALR  = 6'h2D, OP_TRAP  = 6'h2E, OP_RFX   = 6'h2F;
    localparam logic [5:0] OP_LDW   = 6'h30, OP_LDH   = 6'h31, OP_LDHU  = 6'h32, OP_LDB   = 6'h33;
    localparam logic [5:0] OP_LDBU  = 6'h34, OP_STW   = 6'h35, OP_STH   = 6'h36, OP_STB   = 6'h37;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_ZEXT,
        IMM_SEXT,
        IMM_HIGH,
        IMM_BRANCH,
        IMM_JUMP
    } imm_kind_e;

    // op_rrb qualifies op_jmp/op_jal: the jump target comes from register rx.
    typedef struct packed {
        logic        op_add, op_sub, op_mul, op_div, op_rem;
        logic        op_and, op_or, op_xor, op_xnor;
        logic        op_sll, op_slr, op_sar, op_ldhi;
        logic        op_beq, op_bne, op_ble, op_bleu, op_blt;
        logic        op_bltu, op_bge, op_bgeu, op_bgt, op_bgtu;
        logic        op_jmp, op_jal, op_rrb, op_trap, op_rfx;
        logic        op_load, op_store;
        logic        signed_div;
        logic        imm_sel;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        rf_we;
        logic        illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    function automatic logic [31:0] extend_imm(input imm_kind_e kind, input logic [25:0] field);
        case (kind)
            IMM_ZEXT:   return {16'h0000, field[15:0]};
            IMM_SEXT:   return {{16{field[15]}}, field[15:0]};
            IMM_HIGH:   return {field[15:0], 16'h0000};
            IMM_BRANCH: return {{14{field[15]}}, field[15:0], 2'b00};
            IMM_JUMP:   return {{4{field[25]}}, field[25:0], 2'b00};
            default:    return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/eco32f_decode_comb.sv
// Pure combinational decode of one ECO32 instruction word into the control bundle.
// ECO32F_DIV_EN enables the div/rem opcodes; otherwise they decode as illegal.
module eco32f_decode_comb
    import eco32f_pkg::*;
(
    input  logic [31:0] insn,
    output ctrl_t       ctrl,
    output logic        rx_used,
    output logic        ry_used
);

    logic [5:0] opcode;
    logic [4:0] ry_field;
    logic [4:0] rd_field;
    imm_kind_e  kind;
    logic       writes;

    assign opcode   = insn[31:26];
    assign ry_field = insn[20:16];
    assign rd_field = insn[15:11];

    always_comb begin
        ctrl    = CTRL_BUBBLE;
        kind    = IMM_NONE;
        writes  = 1'b0;
        rx_used = 1'b0;
        ry_used = 1'b0;

        case (opcode)
            OP_ADD, OP_ADDI:                      ctrl.op_add = 1'b1;
            OP_SUB, OP_SUBI:                      ctrl.op_sub = 1'b1;
            OP_MUL, OP_MULI, OP_MULU, OP_MULUI:   ctrl.op_mul = 1'b1;
`ifdef ECO32F_DIV_EN
            OP_DIV, OP_DIVI, OP_DIVU, OP_DIVUI:   ctrl.op_div = 1'b1;
            OP_REM, OP_REMI, OP_REMU, OP_REMUI:   ctrl.op_rem = 1'b1;
`else
            OP_DIV, OP_DIVI, OP_DIVU, OP_DIVUI,
            OP_REM, OP_REMI, OP_REMU, OP_REMUI:   ctrl.illegal = 1'b1;
`endif
            OP_AND, OP_ANDI:                      ctrl.op_and = 1'b1;
            OP_OR, OP_ORI:                        ctrl.op_or = 1'b1;
            OP_XOR, OP_XORI:                      ctrl.op_xor = 1'b1;
            OP_XNOR, OP_XNORI:                    ctrl.op_xnor = 1'b1;
            OP_SLL, OP_SLLI:                      ctrl.op_sll = 1'b1;
            OP_SLR, OP_SLRI:                      ctrl.op_slr = 1'b1;
            OP_SAR, OP_SARI:                      ctrl.op_sar = 1'b1;
            OP_LDHI:                              ctrl.op_ldhi = 1'b1;
            OP_BEQ:                               ctrl.op_beq = 1'b1;
            OP_BNE:                               ctrl.op_bne = 1'b1;
            OP_BLE:                               ctrl.op_ble = 1'b1;
            OP_BLEU:                              ctrl.op_bleu = 1'b1;
            OP_BLT:                               ctrl.op_blt = 1'b1;
            OP_BLTU:                              ctrl.op_bltu = 1'b1;
            OP_BGE:                               ctrl.op_bge = 1'b1;
            OP_BGEU:                              ctrl.op_bgeu = 1'b1;
            OP_BGT:                               ctrl.op_bgt = 1'b1;
            OP_BGTU:                              ctrl.op_bgtu = 1'b1;
            OP_J:                                 ctrl.op_jmp = 1'b1;
            OP_JR:    begin ctrl.op_jmp = 1'b1;   ctrl.op_rrb = 1'b1; end
            OP_JAL:                               ctrl.op_jal = 1'b1;
            OP_JALR:  begin ctrl.op_jal = 1'b1;   ctrl.op_rrb = 1'b1; end
            OP_TRAP:                              ctrl.op_trap = 1'b1;
            OP_RFX:                               ctrl.op_rfx = 1'b1;
            OP_LDW, OP_LDH, OP_LDHU, OP_LDB, OP_LDBU: ctrl.op_load = 1'b1;
            OP_STW, OP_STH, OP_STB:               ctrl.op_store = 1'b1;
            default:                              ctrl.illegal = 1'b1;
        endcase

        // Operand usage, writeback target and immediate kind per format class.
        if (!ctrl.illegal) begin
            if (opcode <= OP_SARI) begin
                rx_used         = 1'b1;
                ry_used         = ~opcode[0];
                writes          = 1'b1;
                ctrl.imm_sel    = opcode[0];
                ctrl.rd         = opcode[0] ? ry_field : rd_field;
                ctrl.signed_div = (ctrl.op_div | ctrl.op_rem) & ~opcode[1];
                if (opcode[0])
                    kind = (opcode < OP_AND) ? IMM_SEXT : IMM_ZEXT;
            end else if (ctrl.op_ldhi) begin
                writes  = 1'b1;
                ctrl.rd = ry_field;
                kind    = IMM_HIGH;
            end else if (opcode >= OP_BEQ && opcode <= OP_BGTU) begin
                rx_used = 1'b1;
                ry_used = 1'b1;
                kind    = IMM_BRANCH;
            end else if (ctrl.op_jmp | ctrl.op_jal) begin
                rx_used = ctrl.op_rrb;
                kind    = ctrl.op_rrb ? IMM_NONE : IMM_JUMP;
                if (ctrl.op_jal) begin
                    writes  = 1'b1;
                    ctrl.rd = 5'd31;
                end
            end else if (ctrl.op_load) begin
                rx_used = 1'b1;
                writes  = 1'b1;
                ctrl.rd = ry_field;
                kind    = IMM_SEXT;
            end else if (ctrl.op_store) begin
                rx_used = 1'b1;
                ry_used = 1'b1;
                kind    = IMM_SEXT;
            end
        end

        ctrl.imm   = extend_imm(kind, insn[25:0]);
        ctrl.rf_we = writes & (ctrl.rd != 5'd0);
    end

endmodule

// File: rtl/eco32f_decode.sv
// eco32f ID stage: decode, load-use interlock and the ID/EX pipeline register.
// Build with ECO32F_DIV_EN to decode div/rem; otherwise those opcodes trap as illegal.
module eco32f_decode
    import eco32f_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hE000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_insn,
    input  logic [31:0] if_pc,
    input  logic        if_valid,
    input  logic        id_flush,
    input  logic        ex_stall,
    output logic        id_hazard,
    output logic [4:0]  id_rx_addr,
    output logic [4:0]  id_ry_addr,
    output logic        ex_op_add,
    output logic        ex_op_sub,
    output logic        ex_op_mul,
    output logic        ex_op_div,
    output logic        ex_op_rem,
    output logic        ex_op_and,
    output logic        ex_op_or,
    output logic        ex_op_xor,
    output logic        ex_op_xnor,
    output logic        ex_op_sll,
    output logic        ex_op_slr,
    output logic        ex_op_sar,
    output logic        ex_op_ldhi,
    output logic        ex_op_beq,
    output logic        ex_op_bne,
    output logic        ex_op_ble,
    output logic        ex_op_bleu,
    output logic        ex_op_blt,
    output logic        ex_op_bltu,
    output logic        ex_op_bge,
    output logic        ex_op_bgeu,
    output logic        ex_op_bgt,
    output logic        ex_op_bgtu,
    output logic        ex_op_jmp,
    output logic        ex_op_jal,
    output logic        ex_op_rrb,
    output logic        ex_op_trap,
    output logic        ex_op_rfx,
    output logic        ex_op_load,
    output logic        ex_op_store,
    output logic        ex_signed_div,
    output logic [31:0] ex_imm,
    output logic        ex_imm_sel,
    output logic [4:0]  ex_rd,
    output logic        ex_rf_we,
    output logic [31:0] ex_pc,
    output logic        ex_illegal
);

    ctrl_t dec_ctrl;
    ctrl_t ex_q;
    logic  rx_used;
    logic  ry_used;
    logic  issue;

    eco32f_decode_comb u_comb (
        .insn    (if_insn),
        .ctrl    (dec_ctrl),
        .rx_used (rx_used),
        .ry_used (ry_used)
    );

    assign id_rx_addr = if_insn[25:21];
    assign id_ry_addr = if_insn[20:16];

    // A load in EX cannot forward to the very next instruction; stall it one cycle.
    assign id_hazard = ex_q.op_load & ex_q.rf_we & if_valid &
                       ((rx_used & (ex_q.rd == id_rx_addr)) |
                        (ry_used & (ex_q.rd == id_ry_addr)));

    assign issue = if_valid & ~id_flush & ~id_hazard;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q  <= CTRL_BUBBLE;
            ex_pc <= RESET_PC;
        end else if (!ex_stall) begin
            ex_q  <= issue ? dec_ctrl : CTRL_BUBBLE;
            ex_pc <= if_pc;
        end
    end

    assign ex_op_add     = ex_q.op_add;
    assign ex_op_sub     = ex_q.op_sub;
    assign ex_op_mul     = ex_q.op_mul;
    assign ex_op_div     = ex_q.op_div;
    assign ex_op_rem     = ex_q.op_rem;
    assign ex_op_and     = ex_q.op_and;
    assign ex_op_or      = ex_q.op_or;
    assign ex_op_xor     = ex_q.op_xor;
    assign ex_op_xnor    = ex_q.op_xnor;
    assign ex_op_sll     = ex_q.op_sll;
    assign ex_op_slr     = ex_q.op_slr;
    assign ex_op_sar     = ex_q.op_sar;
    assign ex_op_ldhi    = ex_q.op_ldhi;
    assign ex_op_beq     = ex_q.op_beq;
    assign ex_op_bne     = ex_q.op_bne;
    assign ex_op_ble     = ex_q.op_ble;
    assign ex_op_bleu    = ex_q.op_bleu;
    assign ex_op_blt     = ex_q.op_blt;
    assign ex_op_bltu    = ex_q.op_bltu;
    assign ex_op_bge     = ex_q.op_bge;
    assign ex_op_bgeu    = ex_q.op_bgeu;
    assign ex_op_bgt     = ex_q.op_bgt;
    assign ex_op_bgtu    = ex_q.op_bgtu;
    assign ex_op_jmp     = ex_q.op_jmp;
    assign ex_op_jal     = ex_q.op_jal;
    assign ex_op_rrb     = ex_q.op_rrb;
    assign ex_op_trap    = ex_q.op_trap;
    assign ex_op_rfx     = ex_q.op_rfx;
    assign ex_op_load    = ex_q.op_load;
    assign ex_op_store   = ex_q.op_store;
    assign ex_signed_div = ex_q.signed_div;
    assign ex_imm        = ex_q.imm;
    assign ex_imm_sel    = ex_q.imm_sel;
    assign ex_rd         = ex_q.rd;
    assign ex_rf_we      = ex_q.rf_we;
    assign ex_illegal    = ex_q.illegal;

endmodule

// File: tb/tb_eco32f_decode.sv
// Randomised scoreboard bench for eco32f_decode against an opcode-table reference model.
// Honours ECO32F_DIV_EN the same way as the design build.
module tb_eco32f_decode;

    localparam logic [31:0] RESET_PC = 32'hE000_0000;
`ifdef ECO32F_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] if_insn = '0;
    logic [31:0] if_pc = '0;
    logic        if_valid = 1'b0;
    logic        id_flush = 1'b0;
    logic        ex_stall = 1'b0;
    logic        id_hazard;
    logic [4:0]  id_rx_addr, id_ry_addr;
    logic ex_op_add, ex_op_sub, ex_op_mul, ex_op_div, ex_op_rem, ex_op_and, ex_op_or, ex_op_xor;
    logic ex_op_xnor, ex_op_sll, ex_op_slr, ex_op_sar, ex_op_ldhi, ex_op_beq, ex_op_bne, ex_op_ble;
    logic ex_op_bleu, ex_op_blt, ex_op_bltu, ex_op_bge, ex_op_bgeu, ex_op_bgt, ex_op_bgtu;
    logic ex_op_jmp, ex_op_jal, ex_op_rrb, ex_op_trap, ex_op_rfx, ex_op_load, ex_op_store;
    logic        ex_signed_div, ex_imm_sel, ex_rf_we, ex_illegal;
    logic [31:0] ex_imm, ex_pc;
    logic [4:0]  ex_rd;

    // ops bit order: add sub mul div rem and or xor xnor sll slr sar ldhi
    // beq..bgtu(13..22) jmp jal rrb trap rfx load store(29)
    typedef struct packed {
        logic [29:0] ops;
        logic        signed_div;
        logic        imm_sel;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        rf_we;
        logic        illegal;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    exp_t model_ex;
    exp_t reset_exp;
    int   vectors = 0;
    int   miscompares = 0;
    int   alu_idx [15] = '{0, 1, 2, 2, 3, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11};

    always #5 clk = ~clk;

    eco32f_decode dut (
        .clk(clk), .rst(rst), .if_insn(if_insn), .if_pc(if_pc), .if_valid(if_valid),
        .id_flush(id_flush), .ex_stall(ex_stall), .id_hazard(id_hazard),
        .id_rx_addr(id_rx_addr), .id_ry_addr(id_ry_addr),
        .ex_op_add(ex_op_add), .ex_op_sub(ex_op_sub), .ex_op_mul(ex_op_mul), .ex_op_div(ex_op_div),
        .ex_op_rem(ex_op_rem), .ex_op_and(ex_op_and), .ex_op_or(ex_op_or), .ex_op_xor(ex_op_xor),
        .ex_op_xnor(ex_op_xnor), .ex_op_sll(ex_op_sll), .ex_op_slr(ex_op_slr), .ex_op_sar(ex_op_sar),
        .ex_op_ldhi(ex_op_ldhi), .ex_op_beq(ex_op_beq), .ex_op_bne(ex_op_bne), .ex_op_ble(ex_op_ble),
        .ex_op_bleu(ex_op_bleu), .ex_op_blt(ex_op_blt), .ex_op_bltu(ex_op_bltu), .ex_op_bge(ex_op_bge),
        .ex_op_bgeu(ex_op_bgeu), .ex_op_bgt(ex_op_bgt), .ex_op_bgtu(ex_op_bgtu), .ex_op_jmp(ex_op_jmp),
        .ex_op_jal(ex_op_jal), .ex_op_rrb(ex_op_rrb), .ex_op_trap(ex_op_trap), .ex_op_rfx(ex_op_rfx),
        .ex_op_load(ex_op_load), .ex_op_store(ex_op_store), .ex_signed_div(ex_signed_div),
        .ex_imm(ex_imm), .ex_imm_sel(ex_imm_sel), .ex_rd(ex_rd), .ex_rf_we(ex_rf_we),
        .ex_pc(ex_pc), .ex_illegal(ex_illegal)
    );

    function automatic logic [31:0] enc_rrr(input logic [5:0] op, input logic [4:0] rx, input logic [4:0] ry, input logic [4:0] rd);
        return {op, rx, ry, rd, 11'h000};
    endfunction

    function automatic logic [31:0] enc_rri(input logic [5:0] op, input logic [4:0] rx, input logic [4:0] ry, input logic [15:0] imm);
        return {op, rx, ry, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] off);
        return {op, off};
    endfunction

    // Reference decode straight from the ISA tables: opcode ranges and plain arithmetic.
    function automatic exp_t decode_ref(input logic [31:0] insn, input logic [31:0] pc);
        exp_t        e;
        int          o;
        int          idx;
        bit          writes;
        logic [4:0]  rd;
        logic [31:0] s16, z16, s26;
        o      = int'(insn[31:26]);
        s16    = {{16{insn[15]}}, insn[15:0]};
        z16    = {16'h0000, insn[15:0]};
        s26    = {{6{insn[25]}}, insn[25:0]};
        e      = '0;
        e.pc   = pc;
        idx    = -1;
        writes = 1'b0;
        rd     = 5'd0;
        if (o <= 'h1D) begin
            if (DIV_EN || o < 8 || o > 15) begin
                idx          = alu_idx[o / 2];
                writes       = 1'b1;
                rd           = (o % 2 == 1) ? insn[20:16] : insn[15:11];
                e.imm_sel    = (o % 2 == 1);
                e.imm        = (o % 2 == 0) ? 32'h0 : ((o < 16) ? s16 : z16);
                e.signed_div = (o >= 8 && o <= 15 && (o % 4) < 2);
            end
        end else if (o == 'h1F) begin
            idx = 12; writes = 1'b1; rd = insn[20:16]; e.imm = {insn[15:0], 16'h0000};
        end else if (o >= 'h20 && o <= 'h29) begin
            idx = 13 + (o - 'h20); e.imm = s16 << 2;
        end else if (o == 'h2A || o == 'h2B) begin
            idx = 23; if (o == 'h2A) e.imm = s26 << 2; else e.ops[25] = 1'b1;
        end else if (o == 'h2C || o == 'h2D) begin
            idx = 24; writes = 1'b1; rd = 5'd31;
            if (o == 'h2C) e.imm = s26 << 2; else e.ops[25] = 1'b1;
        end else if (o == 'h2E) begin
            idx = 26;
        end else if (o == 'h2F) begin
            idx = 27;
        end else if (o >= 'h30 && o <= 'h34) begin
            idx = 28; writes = 1'b1; rd = insn[20:16]; e.imm = s16;
        end else if (o >= 'h35 && o <= 'h37) begin
            idx = 29; e.imm = s16;
        end
        if (idx < 0) e.illegal = 1'b1;
        else e.ops[idx] = 1'b1;
        e.rd    = rd;
        e.rf_we = writes && (rd != 5'd0);
        return e;
    endfunction

    function automatic void uses_ref(input logic [31:0] insn, output bit ux, output bit uy);
        int o;
        bit alu, br;
        o   = int'(insn[31:26]);
        alu = (o <= 'h1D) && (DIV_EN || o < 8 || o > 15);
        br  = (o >= 'h20 && o <= 'h29);
        ux  = alu || br || o == 'h2B || o == 'h2D || (o >= 'h30 && o <= 'h37);
        uy  = (alu && o % 2 == 0) || br || (o >= 'h35 && o <= 'h37);
    endfunction

    function automatic exp_t observed();
        exp_t a;
        a.ops = {ex_op_store, ex_op_load, ex_op_rfx, ex_op_trap, ex_op_rrb, ex_op_jal, ex_op_jmp,
                 ex_op_bgtu, ex_op_bgt, ex_op_bgeu, ex_op_bge, ex_op_bltu, ex_op_blt,
                 ex_op_bleu, ex_op_ble, ex_op_bne, ex_op_beq,
                 ex_op_ldhi, ex_op_sar, ex_op_slr, ex_op_sll, ex_op_xnor, ex_op_xor, ex_op_or, ex_op_and,
                 ex_op_rem, ex_op_div, ex_op_mul, ex_op_sub, ex_op_add};
        a.signed_div = ex_signed_div;
        a.imm_sel    = ex_imm_sel;
        a.imm        = ex_imm;
        a.rd         = ex_rd;
        a.rf_we      = ex_rf_we;
        a.illegal    = ex_illegal;
        a.pc         = ex_pc;
        return a;
    endfunction

    task automatic check_output(input string name, input logic [127:0] got, input logic [127:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, got, want);
        end
    endtask

    // Drives one ID cycle, checks the combinational outputs and queues the expected EX state.
    task automatic apply_stimulus(input logic [31:0] insn, input logic [31:0] pc,
                                  input bit valid, input bit flush, input bit stall, output bit hz);
        bit   ux, uy;
        exp_t nxt;
        @(negedge clk);
        if_insn  = insn;
        if_pc    = pc;
        if_valid = valid;
        id_flush = flush;
        ex_stall = stall;
        uses_ref(insn, ux, uy);
        hz = model_ex.ops[28] && model_ex.rf_we && valid &&
             ((ux && model_ex.rd == insn[25:21]) || (uy && model_ex.rd == insn[20:16]));
        #1;
        check_output("id_hazard_addr", {id_hazard, id_rx_addr, id_ry_addr}, {hz, insn[25:21], insn[20:16]});
        if (stall) nxt = model_ex;
        else if (valid && !flush && !hz) nxt = decode_ref(insn, pc);
        else begin
            nxt    = '0;
            nxt.pc = pc;
        end
        model_ex = nxt;
        exp_q.push_back(nxt);
    endtask

    task automatic reset_during_stall();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_output("async_reset", observed(), reset_exp);
        @(negedge clk);
        rst      = 1'b1;
        model_ex = reset_exp;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output("ex_bundle", observed(), e);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        bit          hz;
        logic [31:0] insn, pc;
        bit          valid, flush, stall;
        int          waited;
        reset_exp    = '0;
        reset_exp.pc = RESET_PC;
        model_ex     = reset_exp;
        #1 rst = 1'b0;
        #1 check_output("reset_state", observed(), reset_exp);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        apply_stimulus(enc_rrr(6'h00, 5'd1, 5'd2, 5'd3), 32'h1000, 1, 0, 0, hz);
        apply_stimulus(enc_rri(6'h13, 5'd4, 5'd5, 16'h8000), 32'h1004, 1, 0, 0, hz);
        apply_stimulus(enc_rri(6'h01, 5'd4, 5'd5, 16'h8000), 32'h1008, 1, 0, 0, hz);
        apply_stimulus(enc_rri(6'h30, 5'd1, 5'd7, 16'h0004), 32'h100C, 1, 0, 0, hz);
        apply_stimulus(enc_rrr(6'h00, 5'd7, 5'd0, 5'd8), 32'h1010, 1, 0, 0, hz);
        apply_stimulus(enc_rrr(6'h00, 5'd7, 5'd0, 5'd8), 32'h1010, 1, 0, 0, hz);
        apply_stimulus(enc_rrr(6'h00, 5'd1, 5'd2, 5'd3), 32'h1014, 1, 1, 0, hz);
        apply_stimulus(enc_rrr(6'h02, 5'd1, 5'd2, 5'd9), 32'h1018, 1, 0, 0, hz);
        for (int i = 0; i < 3; i++)
            apply_stimulus(enc_rri(6'h11, 5'd3, 5'd4, 16'h00FF), 32'h101C, 1, 0, 1, hz);
        apply_stimulus(32'hFC00_0000, 32'h1020, 1, 0, 0, hz);
        apply_stimulus(enc_rrr(6'h0A, 5'd2, 5'd3, 5'd1), 32'h1024, 1, 0, 0, hz);
        apply_stimulus(enc_j(6'h2C, 26'h3FF_FFFF), 32'h0000_0100, 1, 0, 0, hz);
        apply_stimulus(enc_rrr(6'h00, 5'd1, 5'd2, 5'd3), 32'h0104, 1, 0, 0, hz);
        apply_stimulus(enc_rrr(6'h04, 5'd1, 5'd2, 5'd3), 32'h0108, 1, 0, 1, hz);
        reset_during_stall();

        pc    = 32'h2000;
        insn  = 32'h0;
        valid = 1'b0;
        hz    = 1'b0;
        stall = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!(valid && (hz || stall))) begin
                insn        = $urandom;
                insn[31:26] = 6'($urandom_range(0, 63));
                insn[25:21] = 5'($urandom_range(0, 7));
                insn[20:16] = 5'($urandom_range(0, 7));
                if ($urandom_range(0, 3) == 0) insn[15:11] = 5'($urandom_range(0, 7));
                pc = pc + 32'd4;
            end
            valid = ($urandom_range(0, 9) < 8);
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 99) < 15);
            apply_stimulus(insn, pc, valid, flush, stall, hz);
        end

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            #2;
            waited++;
        end
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d expected entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
